// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle MIPS sequencer and its datapath/memory.
// The sequencer (master) drives every enable and select; the datapath returns opcode and status.
interface multicycle_control_fsm_if;
    logic [5:0] OP;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic [1:0] PCSource;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic       Fault;
    logic [3:0] State;

    modport master (
        input  OP, Zero, MemReady,
        output PCWrite, PCSource, IorD, MemRead, MemWrite, IRWrite,
               RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, Fault, State
    );

    modport slave (
        output OP, Zero, MemReady,
        input  PCWrite, PCSource, IorD, MemRead, MemWrite, IRWrite,
               RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, Fault, State
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS sequencer: walks each instruction through its states, drives all datapath
// controls, and traps unsupported opcodes or stalled memory accesses into a sticky FAULT.
module multicycle_control_fsm #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_control_fsm_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_J    = 6'h02;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        R_WB      = 4'd7,
        EXEC_I    = 4'd8,
        I_WB      = 4'd9,
        BRANCH    = 4'd10,
        JUMP      = 4'd11,
        FAULT     = 4'd15
    } state_t;

    state_t           state, nextState;
    logic [CNT_W-1:0] waitCnt, waitCntNext;
    logic             isWait, timedOut;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FETCH;
            waitCnt <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= waitCntNext;
        end
    end

    assign isWait   = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
    // MemReady is checked before timedOut in the decode, so a late completion still wins.
    assign timedOut = isWait && !bus.MemReady && (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        nextState    = state;
        bus.PCWrite  = 1'b0;
        bus.PCSource = 2'b00;
        bus.IorD     = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.RegDst   = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.RegWrite = 1'b0;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = 2'b00;
        bus.ALUOp    = 3'b000;
        bus.Fault    = 1'b0;
        case (state)
            FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                if (bus.MemReady) begin
                    bus.IRWrite = 1'b1;
                    bus.PCWrite = 1'b1;
                    nextState   = DECODE;
                end else if (timedOut) begin
                    nextState = FAULT;
                end
            end
            DECODE: begin
                bus.ALUSrcB = 2'b11;
                case (bus.OP)
                    OP_LW, OP_SW:           nextState = MEM_ADDR;
                    OP_R:                   nextState = EXEC_R;
                    OP_ADDI, OP_ORI, OP_LUI: nextState = EXEC_I;
                    OP_BEQ, OP_BNE:         nextState = BRANCH;
                    OP_J:                   nextState = JUMP;
                    default:                nextState = FAULT;
                endcase
            end
            MEM_ADDR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                nextState   = (bus.OP == OP_LW) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                if (bus.MemReady)  nextState = MEM_WB;
                else if (timedOut) nextState = FAULT;
            end
            MEM_WB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
                nextState    = FETCH;
            end
            MEM_WRITE: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                if (bus.MemReady)  nextState = FETCH;
                else if (timedOut) nextState = FAULT;
            end
            EXEC_R: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 3'b111;
                nextState   = R_WB;
            end
            R_WB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
                nextState    = FETCH;
            end
            EXEC_I: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                if (bus.OP == OP_ORI)      bus.ALUOp = 3'b010;
                else if (bus.OP == OP_LUI) bus.ALUOp = 3'b011;
                nextState = I_WB;
            end
            I_WB: begin
                bus.RegWrite = 1'b1;
                nextState    = FETCH;
            end
            BRANCH: begin
                bus.ALUSrcA  = 1'b1;
                bus.ALUOp    = 3'b001;
                bus.PCSource = 2'b01;
                bus.PCWrite  = ((bus.OP == OP_BEQ) && bus.Zero) || ((bus.OP == OP_BNE) && !bus.Zero);
                nextState    = FETCH;
            end
            JUMP: begin
                bus.PCSource = 2'b10;
                bus.PCWrite  = 1'b1;
                nextState    = FETCH;
            end
            FAULT: begin
                bus.Fault = 1'b1;
            end
            default: nextState = FAULT;
        endcase
    end

    // Counter measures cycles spent in the current wait-state visit only.
    assign waitCntNext = (isWait && (nextState == state) && !bus.MemReady) ? waitCnt + CNT_W'(1) : '0;
    assign bus.State   = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for the multicycle sequencer: a per-instruction path model checked every cycle,
// plus directed scenarios with hand-computed state traces and latencies.
module tb_multicycle_control_fsm;
    localparam int T = 16;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    multicycle_control_fsm_if bus();

    multicycle_control_fsm #(.TIMEOUT_CYCLES(T)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       PCWrite;
        logic [1:0] PCSource;
        logic       IorD;
        logic       MemRead;
        logic       MemWrite;
        logic       IRWrite;
        logic       RegDst;
        logic       MemtoReg;
        logic       RegWrite;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [2:0] ALUOp;
        logic       Fault;
        logic [3:0] State;
    } ctl_t;

    // Model: an instruction is the list of states its opcode visits after FETCH.
    int mState;
    int mVisit;
    int mPrev;
    int path[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mState = 0;
            mVisit = 1;
            path.delete();
        end else begin
            mPrev = mState;
            case (mState)
                0: begin
                    if (bus.MemReady) begin
                        path.delete();
                        case (bus.OP)
                            6'h00:               path = '{1, 6, 7};
                            6'h08, 6'h0D, 6'h0F: path = '{1, 8, 9};
                            6'h23:               path = '{1, 2, 3, 4};
                            6'h2B:               path = '{1, 2, 5};
                            6'h04, 6'h05:        path = '{1, 10};
                            6'h02:               path = '{1, 11};
                            default:             path = '{1, 15};
                        endcase
                        mState = path.pop_front();
                    end else if (mVisit >= T) begin
                        mState = 15;
                    end
                end
                3, 5: begin
                    if (bus.MemReady)     mState = (path.size() > 0) ? path.pop_front() : 0;
                    else if (mVisit >= T) mState = 15;
                end
                15: mState = 15;
                default: mState = (path.size() > 0) ? path.pop_front() : 0;
            endcase
            if (mState != mPrev) mVisit = 1;
            else                 mVisit = mVisit + 1;
        end
    end

    function automatic ctl_t expOut(int st, logic [5:0] op, logic z, logic mr);
        ctl_t e;
        e = '0;
        e.State = 4'(st);
        case (st)
            0:  begin e.MemRead = 1; e.ALUSrcB = 2'b01; e.IRWrite = mr; e.PCWrite = mr; end
            1:  e.ALUSrcB = 2'b11;
            2:  begin e.ALUSrcA = 1; e.ALUSrcB = 2'b10; end
            3:  begin e.MemRead = 1; e.IorD = 1; end
            4:  begin e.RegWrite = 1; e.MemtoReg = 1; end
            5:  begin e.MemWrite = 1; e.IorD = 1; end
            6:  begin e.ALUSrcA = 1; e.ALUOp = 3'b111; end
            7:  begin e.RegWrite = 1; e.RegDst = 1; end
            8:  begin
                e.ALUSrcA = 1; e.ALUSrcB = 2'b10;
                e.ALUOp = (op == 6'h0D) ? 3'b010 : (op == 6'h0F) ? 3'b011 : 3'b000;
            end
            9:  e.RegWrite = 1;
            10: begin
                e.ALUSrcA = 1; e.ALUOp = 3'b001; e.PCSource = 2'b01;
                e.PCWrite = ((op == 6'h04) && z) || ((op == 6'h05) && !z);
            end
            11: begin e.PCSource = 2'b10; e.PCWrite = 1; end
            default: e.Fault = 1;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        ctl_t e, a;
        e = expOut(mState, bus.OP, bus.Zero, bus.MemReady);
        a = {bus.PCWrite, bus.PCSource, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
             bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
             bus.Fault, bus.State};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL cycle_outputs t=%0t got %b required %b", $time, a, e);
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, act, req);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH with MemReady high; reports cycles and branch PCWrite.
    task automatic runInstr(input logic [5:0] op, input logic z, output int cycles, output int brPcw);
        bus.OP = op;
        bus.Zero = z;
        bus.MemReady = 1'b1;
        cycles = 0;
        brPcw = -1;
        for (int i = 0; i < 20; i++) begin
            if (bus.State == 4'd10) brPcw = int'(bus.PCWrite);
            adv();
            cycles++;
            if (bus.State == 4'd0 || bus.State == 4'd15) break;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        int rw, n, inRead, c, pw;
        int addSeq[4];
        int opList[6];
        int latList[6];
        addSeq  = '{1, 6, 7, 0};
        opList  = '{8'h08, 8'h0D, 8'h0F, 8'h2B, 8'h02, 8'h00};
        latList = '{4, 4, 4, 4, 3, 4};

        reset = 1'b0;
        bus.OP = 6'h00;
        bus.Zero = 1'b0;
        bus.MemReady = 1'b0;
        repeat (2) adv();
        chk("reset_state", int'(bus.State), 0);
        chk("reset_memread", int'(bus.MemRead), 1);
        chk("reset_fault", int'(bus.Fault), 0);
        reset = 1'b1;

        // add: 0,1,6,7,0 with a single RegWrite in R_WB
        bus.MemReady = 1'b1;
        bus.OP = 6'h00;
        rw = int'(bus.RegWrite);
        for (int i = 0; i < 4; i++) begin
            adv();
            chk($sformatf("add_state%0d", i), int'(bus.State), addSeq[i]);
            if (bus.State == 4'd7) chk("add_regdst", int'(bus.RegDst), 1);
            rw += int'(bus.RegWrite);
        end
        chk("add_regwrite_count", rw, 1);

        // lw with memory stalled 3 cycles in MEM_READ
        bus.OP = 6'h23;
        n = 0;
        inRead = 0;
        for (int i = 0; i < 30; i++) begin
            adv();
            n++;
            if (bus.State == 4'd3) begin
                inRead++;
                bus.MemReady = (inRead >= 4);
            end
            if (bus.State == 4'd4) chk("lw_memtoreg", int'(bus.MemtoReg), 1);
            if (bus.State == 4'd0 || bus.State == 4'd15) break;
        end
        chk("lw_total_cycles", n, 8);
        chk("lw_read_cycles", inRead, 4);
        chk("lw_end_state", int'(bus.State), 0);

        // branches
        runInstr(6'h04, 1'b1, c, pw);
        chk("beq_z1_pcwrite", pw, 1);
        chk("beq_cycles", c, 3);
        runInstr(6'h04, 1'b0, c, pw);
        chk("beq_z0_pcwrite", pw, 0);
        runInstr(6'h05, 1'b0, c, pw);
        chk("bne_z0_pcwrite", pw, 1);
        runInstr(6'h05, 1'b1, c, pw);
        chk("bne_z1_pcwrite", pw, 0);

        // latencies of the remaining instruction classes
        for (int i = 0; i < 6; i++) begin
            runInstr(6'(opList[i]), 1'b0, c, pw);
            chk($sformatf("latency_op%02h", opList[i]), c, latList[i]);
        end

        // unsupported opcode traps
        bus.OP = 6'h3F;
        bus.MemReady = 1'b1;
        adv();
        adv();
        chk("badop_state", int'(bus.State), 15);
        chk("badop_fault", int'(bus.Fault), 1);
        for (int i = 0; i < 3; i++) begin
            bus.MemReady = i[0];
            adv();
            chk("fault_sticky", int'(bus.State), 15);
            chk("fault_enables", int'({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.MemRead}), 0);
        end
        reset = 1'b0;
        #1;
        chk("fault_reset_state", int'(bus.State), 0);
        adv();
        reset = 1'b1;

        // fetch timeout
        bus.MemReady = 1'b0;
        n = 1;
        for (int i = 0; i < 40; i++) begin
            adv();
            if (bus.State == 4'd0) n++;
            else break;
        end
        chk("timeout_fetch_cycles", n, 16);
        chk("timeout_state", int'(bus.State), 15);
        reset = 1'b0;
        adv();
        reset = 1'b1;

        // MemReady arriving on the last allowed cycle wins
        bus.OP = 6'h00;
        bus.MemReady = 1'b0;
        repeat (15) adv();
        chk("late_ready_still_fetch", int'(bus.State), 0);
        bus.MemReady = 1'b1;
        adv();
        chk("late_ready_decode", int'(bus.State), 1);
        repeat (3) adv();
        chk("late_ready_done", int'(bus.State), 0);

        // reset during MEM_WRITE
        bus.OP = 6'h2B;
        repeat (3) adv();
        chk("sw_state", int'(bus.State), 5);
        bus.MemReady = 1'b0;
        adv();
        chk("sw_hold_memwrite", int'(bus.MemWrite), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("sw_reset_state", int'(bus.State), 0);
        chk("sw_reset_memwrite", int'(bus.MemWrite), 0);
        adv();
        reset = 1'b1;
        bus.OP = 6'h00;
        bus.MemReady = 1'b1;
        adv();
        chk("resume_decode", int'(bus.State), 1);
        repeat (3) adv();
        chk("resume_done", int'(bus.State), 0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
